// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: streams W[0..ROUNDS-1] for one 512-bit block.
// Define SHA_SCHED_READY_EN to honour w_ready backpressure; otherwise w_ready is ignored.
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         w_ready,
    output logic         w_valid,
    output logic [31:0]  w_out,
    output logic [5:0]   w_index,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [31:0] win [0:15];
    logic [5:0]  t;
    logic        advance;
    logic        transfer;
    logic        last_word;
    logic [31:0] new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SHA_SCHED_READY_EN
    assign advance = w_ready;
`else
    // Port kept for interface compatibility; every RUN cycle advances.
    logic unused_w_ready;
    assign unused_w_ready = w_ready;
    assign advance        = 1'b1;
`endif

    assign transfer  = (state == S_RUN) && advance;
    assign last_word = (t == 6'(ROUNDS - 1));
    assign new_word  = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        t     <= 6'd0;
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= block_in[511 - 32*i -: 32];
                        end
                    end
                end
                S_RUN: begin
                    // The window holds W[t..t+15]; each accepted word slides it by one.
                    if (transfer) begin
                        t <= t + 6'd1;
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= new_word;
                        if (last_word) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_valid = (state == S_RUN);
    assign w_out   = win[0];
    assign w_index = t;
    assign busy    = (state == S_RUN) || (state == S_DONE);
    assign done    = (state == S_DONE);

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 64, number of schedule words W[0..ROUNDS-1] emitted per block; legal range 16..64.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a new block; sampled only in IDLE.
REQ-005 SHALL have port block_in  input  512  message block, word 0 in [511:480], word 15 in [31:0]; sampled on the accepted start cycle only.
REQ-006 SHALL have port w_ready  input  1  downstream round stage accepts w_out this cycle.
REQ-007 SHALL have port w_valid  output  1  w_out/w_index hold a valid schedule word.
REQ-008 SHALL have port w_out  output  32  schedule word W[t].
REQ-009 SHALL have port w_index  output  6  current t.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE when the transfer of t=ROUNDS-1 completes; DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL, on the accepted start edge, load a 16-word window win[0..15] with block_in words 0..15 and clear t to 0.
REQ-014 SHALL drive w_valid=1, w_out=win[0], w_index=t throughout RUN, with the first valid word visible in the cycle after the accepted start (latency 1).
REQ-015 SHALL define a transfer as w_valid && w_ready on a rising edge; on each transfer, t increments and the window shifts down by one with win[15] <= new word.
REQ-016 SHALL compute new word = s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32, with carries beyond bit 31 discarded.
REQ-017 SHALL use s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x) and s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x), where SHR is a logical shift (zero fill, never sign fill).
REQ-018 SHALL hold win, t, w_out and w_index stable while w_valid=1 and w_ready=0, for any stall length.
REQ-019 SHALL ignore start while busy=1; start asserted in the DONE cycle is ignored.
REQ-020 SHALL allow a start in the first IDLE cycle after DONE, giving a minimum block-to-block spacing of ROUNDS+2 cycles.
REQ-021 SHALL drive w_valid=0 in IDLE and DONE; w_out/w_index values are don't-care when w_valid=0.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-RUN, immediately force state=IDLE, t=0, window=0, w_valid=0, w_out=0, w_index=0, busy=0, done=0.
REQ-023 SHALL discard a block interrupted by reset; no done pulse is produced for it.
REQ-024 SHALL accept start on the first rising edge after reset deasserts.

Configuration
REQ-025 SHALL honour w_ready as in REQ-015 and REQ-018 when macro SHA_SCHED_READY_EN is defined.
REQ-026 SHALL, when SHA_SCHED_READY_EN is undefined, treat w_ready as constant 1 (port retained, ignored), so one word advances per RUN cycle and RUN lasts exactly ROUNDS cycles.

Verification
REQ-027 SHALL cover: "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; done pulses 1 cycle after W63 transfers.
REQ-028 SHALL cover: all-zero block_in -> all 64 words = 0x00000000; busy high for exactly 65 cycles.
REQ-029 SHALL cover: same "abc" block with w_ready low for 5 cycles at t=17, SHA_SCHED_READY_EN defined -> w_out holds 0x000F0000 and w_index holds 17 during the stall, and the sequence is otherwise identical.
REQ-030 SHALL cover: reset pulsed at t=30 -> next edge shows w_valid=0, busy=0, no done; a new start then yields W0 of the new block at t=0.
REQ-031 SHALL cover: start held high continuously -> blocks begin every 66 cycles; start during RUN/DONE does not restart or reload.
REQ-032 SHALL cover: block_in word1=0x80000000, all other words 0 -> W16 = s0(0x80000000) = 0x11002000, confirming SHR3 uses zero fill.
